fc_layer_scheduler: RTL and testbench

Time-multiplexed sequencer for a fully-connected layer. It drives one shared signed MAC across OUT_SIZE neurons, one at a time. Weights, inputs and biases are streamed by address from external synchronous memories. Each neuron result is emitted with saturation and ReLU over a valid/ready write port. It is the low-area alternative to the fully parallel FC layer.

---
 rtl/fc_layer_scheduler.sv | 156 +++++++++++++++
 tb/tb_fc_layer_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_scheduler.sv
// Time-multiplexed fully-connected layer sequencer: one shared signed MAC walks
// OUT_SIZE neurons, streaming operands from synchronous memories by address.
module fc_layer_scheduler #(
  parameter int IN_SIZE   = 1152,
  parameter int OUT_SIZE  = 10,
  parameter int W         = 8,
  parameter int ACC_WIDTH = 28,
  localparam int IAW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
  localparam int WAW = (OUT_SIZE * IN_SIZE > 1) ? $clog2(OUT_SIZE * IN_SIZE) : 1,
  localparam int NAW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [IAW-1:0]      in_addr,
  input  logic signed [W-1:0] in_data,
  output logic [WAW-1:0]      w_addr,
  input  logic signed [W-1:0] w_data,
  output logic [NAW-1:0]      b_addr,
  input  logic signed [W-1:0] b_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NAW-1:0]      out_idx,
  output logic [W-1:0]        out_data
);

  // state | meaning
  // IDLE  | waiting for start; addresses hold
  // PRIME | first operand addresses of a neuron are on the bus
  // ACCUM | one MAC per cycle, k = 0 .. IN_SIZE-1
  // WRITE | result presented until out_ready
  // DONE  | one-cycle done pulse, busy already low
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    ACCUM = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [IAW-1:0] K_LAST = IAW'(IN_SIZE - 1);
  localparam logic [NAW-1:0] N_LAST = NAW'(OUT_SIZE - 1);

  state_t                      state;
  logic [NAW-1:0]              neuron;
  logic [IAW-1:0]              k;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [2*W-1:0]       prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;

  assign prod     = in_data * w_data;
  assign prod_ext = {{(ACC_WIDTH - 2*W){prod[2*W-1]}}, prod};
  assign bias_ext = {{(ACC_WIDTH - W){b_data[W-1]}}, b_data};

  // Bias is folded into the first product so no extra cycle is spent on it.
  always_comb begin
    acc_next = acc + prod_ext;
    if (k == '0) begin
      acc_next = bias_ext + prod_ext;
    end
  end

  function automatic logic [W-1:0] act(input logic signed [ACC_WIDTH-1:0] a);
    logic [W-1:0] r;
    if (a[ACC_WIDTH-1] || (a == '0)) begin
      r = '0;
    end else if (|a[ACC_WIDTH-2:W-1]) begin
      r = {1'b0, {(W-1){1'b1}}};
    end else begin
      r = a[W-1:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      neuron    <= '0;
      k         <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      in_addr   <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRIME;
            neuron  <= '0;
            busy    <= 1'b1;
            in_addr <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
          end
        end
        PRIME: begin
          state <= ACCUM;
          k     <= '0;
          if (in_addr != K_LAST) begin
            in_addr <= in_addr + 1'b1;
            w_addr  <= w_addr + 1'b1;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          // Addresses run one element ahead of k and park on the last element.
          if (in_addr != K_LAST) begin
            in_addr <= in_addr + 1'b1;
            w_addr  <= w_addr + 1'b1;
          end
          if (k == K_LAST) begin
            state     <= WRITE;
            k         <= '0;
            out_valid <= 1'b1;
            out_idx   <= neuron;
            out_data  <= act(acc_next);
          end
        end
        WRITE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (neuron == N_LAST) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= PRIME;
              neuron  <= neuron + 1'b1;
              in_addr <= '0;
              w_addr  <= w_addr + 1'b1;
              b_addr  <= neuron + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Directed bench for fc_layer_scheduler with a 4-input, 3-neuron layer and
// synchronous operand memories modelled in the bench.
module tb_fc_layer_scheduler;

  localparam int IN_SIZE   = 4;
  localparam int OUT_SIZE  = 3;
  localparam int W         = 8;
  localparam int ACC_WIDTH = 28;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [1:0]        in_addr;
  logic signed [7:0] in_data;
  logic [3:0]        w_addr;
  logic signed [7:0] w_data;
  logic [1:0]        b_addr;
  logic signed [7:0] b_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_idx;
  logic [7:0]        out_data;

  logic signed [7:0] in_mem [4];
  logic signed [7:0] w_mem  [12];
  logic signed [7:0] b_mem  [3];

  int vectors     = 0;
  int miscompares = 0;

  fc_layer_scheduler #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE),
    .W        (W),
    .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  task automatic load_basic();
    for (int i = 0; i < 4; i++) begin
      in_mem[i]   = 8'(i + 1);
      w_mem[i]    = 8'sd1;
      w_mem[4+i]  = -8'sd1;
      w_mem[8+i]  = 8'sd10;
    end
    b_mem[0] = 8'sd0;
    b_mem[1] = 8'sd0;
    b_mem[2] = 8'sd5;
  endtask

  task automatic load_uniform(input logic signed [7:0] iv, input logic signed [7:0] wv,
                              input logic signed [7:0] bv);
    for (int i = 0; i < 4; i++) in_mem[i] = iv;
    for (int i = 0; i < 12; i++) w_mem[i] = wv;
    for (int i = 0; i < 3; i++) b_mem[i] = bv;
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if ({busy, done, out_valid, out_idx, out_data, in_addr, w_addr, b_addr} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: got busy=%b done=%b valid=%b idx=%0d data=%0d in=%0d w=%0d b=%0d want all 0",
               name, busy, done, out_valid, out_idx, out_data, in_addr, w_addr, b_addr);
    end
  endtask

  // One full layer pass observed at every negedge; n counts edges since start was sampled.
  task automatic run_pass(input string name, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input int stall, input int exp_lat,
                          input bit poke_accum, input bit poke_done, input bit check_acc,
                          input logic signed [ACC_WIDTH-1:0] exp_acc, input bit log_addr);
    logic [7:0] exp_data [3];
    int n, nres, ndone, lat, lowcnt;
    bit prev_valid;
    logic [1:0] h_idx, h_in, h_b;
    logic [7:0] h_data;
    logic [3:0] h_w;
    int last_w, last_in, last_b;
    int wq[$];
    int iq[$];
    int bq[$];
    exp_data[0] = e0;
    exp_data[1] = e1;
    exp_data[2] = e2;
    n = 0; nres = 0; ndone = 0; lat = -1; lowcnt = 0; prev_valid = 1'b0;
    last_w = -1; last_in = -1; last_b = -1;
    h_idx = '0; h_in = '0; h_b = '0; h_data = '0; h_w = '0;

    @(negedge clk);
    start = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end

    repeat (60) begin
      start = 1'b0;
      if (out_valid && !prev_valid) begin
        vectors++;
        if (nres >= 3 || out_idx !== 2'(nres) || out_data !== exp_data[nres]) begin
          miscompares++;
          $display("FAIL %s result%0d: got idx=%0d data=%0d want idx=%0d data=%0d",
                   name, nres, out_idx, out_data, nres, (nres < 3) ? exp_data[nres] : 8'd0);
        end
        if (check_acc) begin
          vectors++;
          if (dut.acc !== exp_acc) begin
            miscompares++;
            $display("FAIL %s acc%0d: got %0d want %0d", name, nres, dut.acc, exp_acc);
          end
        end
        h_idx = out_idx; h_data = out_data; h_in = in_addr; h_w = w_addr; h_b = b_addr;
        nres++;
      end
      if (out_valid && prev_valid) begin
        vectors++;
        if (out_idx !== h_idx || out_data !== h_data || in_addr !== h_in ||
            w_addr !== h_w || b_addr !== h_b) begin
          miscompares++;
          $display("FAIL %s stall_hold: got idx=%0d data=%0d in=%0d w=%0d b=%0d want idx=%0d data=%0d in=%0d w=%0d b=%0d",
                   name, out_idx, out_data, in_addr, w_addr, b_addr, h_idx, h_data, h_in, h_w, h_b);
        end
      end
      if (out_valid && !out_ready) begin
        if (lowcnt == stall) out_ready = 1'b1;
        else lowcnt++;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) lat = n + 1;
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s busy_in_done: got %b want 0", name, busy);
        end
        if (poke_done) start = 1'b1;
      end
      if (poke_accum && n == 3) start = 1'b1;
      if (log_addr && busy) begin
        if (int'(w_addr) != last_w) begin last_w = int'(w_addr); wq.push_back(last_w); end
        if (int'(in_addr) != last_in) begin last_in = int'(in_addr); iq.push_back(last_in); end
        if (int'(b_addr) != last_b) begin last_b = int'(b_addr); bq.push_back(last_b); end
      end
      prev_valid = out_valid;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;

    vectors++;
    if (nres != 3 || ndone != 1) begin
      miscompares++;
      $display("FAIL %s counts: got results=%0d dones=%0d want 3 and 1", name, nres, ndone);
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s done_latency: got %0d want %0d", name, lat, exp_lat);
    end
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_after: got busy=%b valid=%b done=%b want 0 0 0", name, busy, out_valid, done);
    end
    if (log_addr) begin
      vectors++;
      if (wq.size() != 12) begin
        miscompares++;
        $display("FAIL %s w_addr_count: got %0d want 12", name, wq.size());
      end else begin
        for (int i = 0; i < 12; i++) begin
          if (wq[i] != i) begin
            miscompares++;
            $display("FAIL %s w_addr_seq[%0d]: got %0d want %0d", name, i, wq[i], i);
            break;
          end
        end
      end
      vectors++;
      if (iq.size() != 12) begin
        miscompares++;
        $display("FAIL %s in_addr_count: got %0d want 12", name, iq.size());
      end else begin
        for (int i = 0; i < 12; i++) begin
          if (iq[i] != i % 4) begin
            miscompares++;
            $display("FAIL %s in_addr_seq[%0d]: got %0d want %0d", name, i, iq[i], i % 4);
            break;
          end
        end
      end
      vectors++;
      if (bq.size() != 3 || bq[0] != 0 || bq[1] != 1 || bq[2] != 2) begin
        miscompares++;
        $display("FAIL %s b_addr_seq: got %0d entries want 0,1,2", name, bq.size());
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    load_basic();
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    reset_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_release");
  endtask

  task automatic test_basic();
    load_basic();
    run_pass("basic", 8'd10, 8'd0, 8'd105, 0, 19, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_saturation();
    load_uniform(8'sd127, 8'sd127, 8'sd127);
    run_pass("saturate", 8'd127, 8'd127, 8'd127, 0, 19, 1'b0, 1'b0, 1'b1, 28'sd64643, 1'b0);
  endtask

  task automatic test_negative();
    load_uniform(-8'sd128, 8'sd127, -8'sd128);
    run_pass("negative", 8'd0, 8'd0, 8'd0, 0, 19, 1'b0, 1'b0, 1'b1, -28'sd65152, 1'b0);
  endtask

  task automatic test_backpressure();
    load_basic();
    run_pass("backpressure", 8'd10, 8'd0, 8'd105, 5, 24, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    load_basic();
    run_pass("start_busy", 8'd10, 8'd0, 8'd105, 0, 19, 1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid_pass();
    load_basic();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || b_addr !== 2'd1) begin
      miscompares++;
      $display("FAIL mid_pass_position: got busy=%b b_addr=%0d want 1 and 1", busy, b_addr);
    end
    reset_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_accum");
    @(negedge clk);
    reset_n = 1'b1;
    run_pass("after_reset", 8'd10, 8'd0, 8'd105, 0, 19, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_pass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
